next_pc_unit: RTL

Parametrised program-counter unit for the 5-stage pipeline: holds the fetch PC in a register, advances it sequentially, and applies stalls and EX-stage redirects. Redirects come from conditional branches, unconditional branches, calls and register returns. An optional circular return-address stack (RAS) supplies return targets. Sits between the EX-stage branch resolution logic and the IF-stage instruction memory; drives the IF/ID flush.

---
 rtl/next_pc_pkg.sv | 15 +
 rtl/next_pc_unit_ras.sv | 57 +++++
 rtl/next_pc_unit.sv | 100 ++++++++++
 3 files changed

// File: rtl/next_pc_pkg.sv
// next_pc_pkg: shared constants and next-PC select encoding
// for the fetch program-counter unit.
package next_pc_pkg;

    localparam int NPC_WIDTH       = 64;
    localparam int NPC_INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        SEQ,
        HOLD,
        BRANCH,
        RETURN
    } npc_sel_e;

endpackage

// File: rtl/next_pc_unit_ras.sv
// return_addr_stack: circular return-address stack that overwrites the
// oldest entry on overflow; push+pop in one cycle replaces the top.
module return_addr_stack #(
    parameter int WIDTH     = 64,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_addr,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]    wptr;
    logic [CW-1:0]    count;
    logic             replace;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(RAS_DEPTH));
    assign top     = mem[wptr - 1'b1];
    assign replace = push & pop & ~empty;
    assign do_push = push & ~replace;
    assign do_pop  = pop & ~push & ~empty;

    // Pointer and occupancy; a full push wraps the pointer over the oldest entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            count <= '0;
        end else if (do_push) begin
            wptr <= wptr + 1'b1;
            if (!full)
                count <= count + 1'b1;
        end else if (do_pop) begin
            wptr  <= wptr - 1'b1;
            count <= count - 1'b1;
        end
    end

    // Entry storage; stale contents are hidden by count after reset.
    always_ff @(posedge clk) begin
        if (replace)
            mem[wptr - 1'b1] <= push_addr;
        else if (do_push)
            mem[wptr] <= push_addr;
    end

endmodule

// File: rtl/next_pc_unit.sv
// next_pc_unit: fetch PC register with sequential advance, stall and EX redirects.
// Define NEXT_PC_RAS_EN to add a return-address stack for Return targets.
module next_pc_unit
    import next_pc_pkg::*;
#(
    parameter int               WIDTH       = NPC_WIDTH,
    parameter int               INSTR_BYTES = NPC_INSTR_BYTES,
    parameter int               IMM_SHIFT   = 2,
    parameter logic [WIDTH-1:0] RESET_PC    = '0,
    parameter int               RAS_DEPTH   = 4
) (
    input  logic             CLK,
    input  logic             Reset_L,
    input  logic             Stall,
    input  logic             Branch,
    input  logic             ALUZero,
    input  logic             Uncondbranch,
    input  logic             Call,
    input  logic             Return,
    input  logic [WIDTH-1:0] BranchPC,
    input  logic [WIDTH-1:0] SignExtImm,
    input  logic [WIDTH-1:0] RegTarget,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PCPlus,
    output logic             Flush,
    output logic             RasEmpty,
    output logic             RasFull
);

    logic             taken;
    logic [WIDTH-1:0] br_target;
    logic [WIDTH-1:0] ret_target;
    logic [WIDTH-1:0] next_pc;
    npc_sel_e         sel;

    assign taken     = Return | Uncondbranch | (Branch & ALUZero);
    assign Flush     = taken;
    assign PCPlus    = PC + WIDTH'(INSTR_BYTES);
    assign br_target = BranchPC + (SignExtImm << IMM_SHIFT);

`ifdef NEXT_PC_RAS_EN
    logic [WIDTH-1:0] ras_top;
    logic             ras_push;

    assign ras_push   = Call & Uncondbranch;
    assign ret_target = RasEmpty ? RegTarget : ras_top;

    return_addr_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (CLK),
        .rst_n     (Reset_L),
        .push      (ras_push),
        .pop       (Return),
        .push_addr (BranchPC + WIDTH'(INSTR_BYTES)),
        .top       (ras_top),
        .empty     (RasEmpty),
        .full      (RasFull)
    );
`else
    logic unused_ras;

    assign ret_target = RegTarget;
    assign RasEmpty   = 1'b1;
    assign RasFull    = 1'b0;
    assign unused_ras = Call ^ RAS_DEPTH[0];
`endif

    // Priority select: redirect beats stall, stall beats sequential.
    always_comb begin
        sel = SEQ;
        if (Return)
            sel = RETURN;
        else if (taken)
            sel = BRANCH;
        else if (Stall)
            sel = HOLD;
    end

    // Next-PC mux driven by the select.
    always_comb begin
        next_pc = PCPlus;
        unique case (sel)
            SEQ:    next_pc = PCPlus;
            HOLD:   next_pc = PC;
            BRANCH: next_pc = br_target;
            RETURN: next_pc = ret_target;
        endcase
    end

    // Fetch PC register.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L)
            PC <= RESET_PC;
        else
            PC <= next_pc;
    end

endmodule
